// File: rtl/microwave_keypad_debouncer_if.sv
// ---------------------------------------------------------------------------
// microwave_keypad_debouncer_if
//   Groups the raw keypad inputs and the qualified key outputs.
//   key_raw_n : 10 raw active-low buttons (bit i = digit i)
//   keypad    : one-hot digit pulse, all-zero when idle
//   key_code  : binary digit 0-9 of the current pulse, 0 when idle
//   key_valid : high exactly while keypad is non-zero
//   master : the button/consumer side (drives key_raw_n)
//   slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface microwave_keypad_debouncer_if;
  logic [9:0] key_raw_n;
  logic [9:0] keypad;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (output key_raw_n, input keypad, input key_code, input key_valid);
  modport slave  (input key_raw_n, output keypad, output key_code, output key_valid);
endinterface

// File: rtl/microwave_keypad_debouncer.sv
// ---------------------------------------------------------------------------
// microwave_keypad_debouncer
//   Turns ten bouncing active-low push buttons into one clean one-hot pulse
//   per qualified press, plus a binary key code and a valid strobe.
//
//   Ports:
//     clock  : system clock, rising edge
//     clearn : asynchronous active-low reset
//     kp     : microwave_keypad_debouncer_if.slave (key_raw_n in;
//              keypad, key_code, key_valid out, all registered)
//
//   Parameters:
//     DEBOUNCE_CYCLES : stable samples needed to accept a press or release
//     PULSE_CYCLES    : clocks each accepted press is presented
//     REPEAT_CYCLES   : held-key repeat interval (repeat build only)
//
//   Optional feature: define MWO_KEY_REPEAT_EN to re-emit the held key every
//   REPEAT_CYCLES clocks spent in HOLD with the same key down.
// ---------------------------------------------------------------------------
module microwave_keypad_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int REPEAT_CYCLES   = 50
) (
  input  logic                          clock,
  input  logic                          clearn,
  microwave_keypad_debouncer_if.slave   kp
);

  // One width serves every counter; each stops at its own terminal value.
  localparam int MAX_DP  = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_DP > REPEAT_CYCLES) ? MAX_DP : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] DEB_END    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES);
`ifdef MWO_KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_END    = CW'(REPEAT_CYCLES);
`endif

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESS, S_HOLD} state_t;

  function automatic logic [3:0] onehot_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t          state_q, state_d;
  logic [9:0]      sync1_q, sync2_q;
  logic [9:0]      cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
`ifdef MWO_KEY_REPEAT_EN
  logic [CW-1:0]   rcpt_q, rcpt_d;
`endif
  logic [9:0]      keypad_q, keypad_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;

  logic [9:0]      sample;
  logic            single;

  assign sample = ~sync2_q;
  assign single = $onehot(sample);

  // State register. Reset lands in HOLD so a key held across reset must be
  // seen released before it can be accepted again.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q     <= S_HOLD;
      sync1_q     <= '1;
      sync2_q     <= '1;
      cand_q      <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      rcnt_q      <= '0;
`ifdef MWO_KEY_REPEAT_EN
      rcpt_q      <= '0;
`endif
      keypad_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      // Two-flop synchroniser: key_raw_n is asynchronous to clock.
      sync1_q     <= kp.key_raw_n;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      rcnt_q      <= rcnt_d;
`ifdef MWO_KEY_REPEAT_EN
      rcpt_q      <= rcpt_d;
`endif
      keypad_q    <= keypad_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state and counter logic.
  // NOTE: every signal gets a default at the top so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    rcnt_d  = rcnt_q;
`ifdef MWO_KEY_REPEAT_EN
    rcpt_d  = rcpt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (single) begin
          cand_d = sample;
          cnt_d  = ONE;
          // With a one-sample debounce the first matching sample is enough.
          if (DEB_END == ONE) begin
            state_d = S_PRESS;
            pcnt_d  = PULSE_LOAD;
            cnt_d   = '0;
          end else begin
            state_d = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (sample != cand_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q + ONE == DEB_END) begin
          state_d = S_PRESS;
          pcnt_d  = PULSE_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_PRESS: begin
        // Inputs are ignored here: the pulse always runs its full length.
        if (pcnt_q == ONE) begin
          state_d = S_HOLD;
          pcnt_d  = '0;
          rcnt_d  = '0;
`ifdef MWO_KEY_REPEAT_EN
          rcpt_d  = '0;
`endif
        end else begin
          pcnt_d = pcnt_q - ONE;
        end
      end
      S_HOLD: begin
        if (sample == '0) begin
          if (rcnt_q + ONE == DEB_END) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + ONE;
          end
        end else begin
          rcnt_d = '0;
        end
`ifdef MWO_KEY_REPEAT_EN
        // cand is zero straight out of reset; never repeat a non-key.
        if ((sample == cand_q) && (cand_q != '0)) begin
          if (rcpt_q + ONE == REP_END) begin
            state_d = S_PRESS;
            pcnt_d  = PULSE_LOAD;
            rcpt_d  = '0;
          end else begin
            rcpt_d = rcpt_q + ONE;
          end
        end else begin
          rcpt_d = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the pulse appears on the
  // same edge that enters PRESS.
  always_comb begin
    keypad_d    = '0;
    key_code_d  = '0;
    key_valid_d = 1'b0;
    if (state_d == S_PRESS) begin
      keypad_d    = cand_d;
      key_code_d  = onehot_index(cand_d);
      key_valid_d = 1'b1;
    end
  end

  assign kp.keypad    = keypad_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_microwave_keypad_debouncer.sv
// ---------------------------------------------------------------------------
// tb_microwave_keypad_debouncer
//   Directed stimulus against microwave_keypad_debouncer with a run-length
//   reference model. Inputs change and literal checks happen 1 time unit
//   after the falling edge; the model advances on the rising edge.
// ---------------------------------------------------------------------------
module tb_microwave_keypad_debouncer;
  localparam int D = 4;
  localparam int P = 2;
  localparam int R = 10;

  logic clock  = 1'b0;
  logic clearn = 1'b0;

  microwave_keypad_debouncer_if kp ();

  microwave_keypad_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clock (clock),
    .clearn(clearn),
    .kp    (kp)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Rules: a key is accepted once the same single key has been seen for D
  // consecutive samples; it is then shown for P clocks; afterwards nothing
  // is accepted until D consecutive all-released samples have been seen.
  // Samples lag the pins by two clocks.
  logic [9:0] pin_hist[$] = '{10'h3FF, 10'h3FF};
  int         pulse_left  = 0;
  bit         releasing   = 1'b1;
  int         zero_run    = 0;
  int         arm_run     = 0;
  int         rep_run     = 0;
  logic [9:0] m_key       = '0;
  logic [9:0] exp_keypad  = '0;
  logic [3:0] exp_code    = '0;
  logic       exp_valid   = 1'b0;

  always @(posedge clock or negedge clearn) begin
    logic [9:0] s;
    if (!clearn) begin
      pin_hist   = '{10'h3FF, 10'h3FF};
      pulse_left = 0;
      releasing  = 1'b1;
      zero_run   = 0;
      arm_run    = 0;
      rep_run    = 0;
      m_key      = '0;
    end else begin
      s = ~pin_hist.pop_front();
      pin_hist.push_back(kp.key_raw_n);
      if (pulse_left > 0) begin
        pulse_left--;
        if (pulse_left == 0) begin
          releasing = 1'b1;
          zero_run  = 0;
          rep_run   = 0;
        end
      end else if (releasing) begin
        zero_run = (s == '0) ? zero_run + 1 : 0;
        if (zero_run == D) begin
          releasing = 1'b0;
          arm_run   = 0;
        end
`ifdef MWO_KEY_REPEAT_EN
        rep_run = (s == m_key && m_key != '0) ? rep_run + 1 : 0;
        if (rep_run == R) begin
          pulse_left = P;
          rep_run    = 0;
        end
`endif
      end else begin
        if (arm_run > 0) arm_run = (s == m_key) ? arm_run + 1 : 0;
        else if ($countones(s) == 1) begin
          m_key   = s;
          arm_run = 1;
        end
        if (arm_run == D) begin
          pulse_left = P;
          arm_run    = 0;
        end
      end
    end
    exp_keypad = (pulse_left > 0) ? m_key : 10'h000;
    exp_valid  = (pulse_left > 0);
    exp_code   = 4'd0;
    for (int i = 0; i < 10; i++) if (exp_keypad[i]) exp_code = 4'(i);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    check("keypad",    32'(kp.keypad),    32'(exp_keypad));
    check("key_code",  32'(kp.key_code),  32'(exp_code));
    check("key_valid", 32'(kp.key_valid), 32'(exp_valid));
    if (kp.key_valid && !prev_valid) pulse_cnt++;
    prev_valid = kp.key_valid;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [9:0] kpd, input logic [3:0] code);
    check({name, "_keypad"},    32'(kp.keypad),    32'(kpd));
    check({name, "_key_code"},  32'(kp.key_code),  32'(code));
    check({name, "_key_valid"}, 32'(kp.key_valid), 32'(kpd != 10'h000));
  endtask

  initial begin
    int base;
    kp.key_raw_n = 10'h3FF;
    clearn = 1'b0;

    // Reset with all keys released, then idle.
    tick(1);
    expect_out("reset", 10'h000, 4'd0);
    tick(2);
    clearn = 1'b1;
    tick(20);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);

    // Digit 1, clean press held 20 clocks.
    base = pulse_cnt;
    kp.key_raw_n = 10'h3FD;
    tick(5);  expect_out("d1_e5", 10'h000, 4'd0);
    tick(1);  expect_out("d1_e6", 10'h002, 4'd1);
    tick(1);  expect_out("d1_e7", 10'h002, 4'd1);
    tick(1);  expect_out("d1_e8", 10'h000, 4'd0);
    tick(12);
`ifdef MWO_KEY_REPEAT_EN
    check("d1_pulses", 32'(pulse_cnt - base), 32'd2);
`else
    check("d1_pulses", 32'(pulse_cnt - base), 32'd1);
`endif
    kp.key_raw_n = 10'h3FF;
    tick(10);

    // Digit 8 bouncing, then stable for 10 clocks.
    base = pulse_cnt;
    kp.key_raw_n = 10'h2FF; tick(2);
    kp.key_raw_n = 10'h3FF; tick(1);
    kp.key_raw_n = 10'h2FF; tick(2);
    kp.key_raw_n = 10'h3FF; tick(1);
    kp.key_raw_n = 10'h2FF;
    tick(5);  expect_out("d8_e5", 10'h000, 4'd0);
    tick(1);  expect_out("d8_e6", 10'h100, 4'd8);
    tick(4);
    kp.key_raw_n = 10'h3FF;
    tick(10);
    check("d8_pulses", 32'(pulse_cnt - base), 32'd1);

    // Digits 3 and 5 together: nothing. Then only 5 held.
    base = pulse_cnt;
    kp.key_raw_n = 10'h3D7;
    tick(20);
    check("d35_pulses", 32'(pulse_cnt - base), 32'd0);
    kp.key_raw_n = 10'h3DF;
    tick(5);  expect_out("d5_e5", 10'h000, 4'd0);
    tick(1);  expect_out("d5_e6", 10'h020, 4'd5);
    tick(4);
    kp.key_raw_n = 10'h3FF;
    tick(10);
    check("d5_pulses", 32'(pulse_cnt - base), 32'd1);

    // Sequence 1,0,0: 5 clocks pressed, 5 released each.
    base = pulse_cnt;
    kp.key_raw_n = 10'h3FD; tick(5);
    kp.key_raw_n = 10'h3FF; tick(1); expect_out("seq1_e6", 10'h002, 4'd1);
    tick(4);
    kp.key_raw_n = 10'h3FE; tick(5);
    kp.key_raw_n = 10'h3FF; tick(1); expect_out("seq0a_e16", 10'h001, 4'd0);
    tick(4);
    kp.key_raw_n = 10'h3FE; tick(5);
    kp.key_raw_n = 10'h3FF; tick(1); expect_out("seq0b_e26", 10'h001, 4'd0);
    tick(10);
    check("seq_pulses", 32'(pulse_cnt - base), 32'd3);

    // Same start, reset mid second pulse with digit 0 still held.
    base = pulse_cnt;
    kp.key_raw_n = 10'h3FD; tick(5);
    kp.key_raw_n = 10'h3FF; tick(5);
    kp.key_raw_n = 10'h3FE; tick(6);
    expect_out("rst_pre", 10'h001, 4'd0);
    clearn = 1'b0;
    #1;
    expect_out("rst_async", 10'h000, 4'd0);
    tick(1);
    clearn = 1'b1;
    tick(20);
    check("rst_held_pulses", 32'(pulse_cnt - base), 32'd2);
    kp.key_raw_n = 10'h3FF; tick(10);
    kp.key_raw_n = 10'h3FE; tick(6);
    expect_out("rst_repress", 10'h001, 4'd0);
    tick(4);
    kp.key_raw_n = 10'h3FF; tick(10);
    check("rst_total_pulses", 32'(pulse_cnt - base), 32'd3);

`ifdef MWO_KEY_REPEAT_EN
    // Digit 9 held: pulses at edges 6, 18, 30. Released after edge 38 so
    // the next repeat slot (edge 42) sees the key already up.
    base = pulse_cnt;
    kp.key_raw_n = 10'h1FF;
    tick(6);  expect_out("rep_e6",  10'h200, 4'd9);
    tick(11); expect_out("rep_e17", 10'h000, 4'd0);
    tick(1);  expect_out("rep_e18", 10'h200, 4'd9);
    tick(12); expect_out("rep_e30", 10'h200, 4'd9);
    tick(8);
    kp.key_raw_n = 10'h3FF;
    tick(16);
    check("rep_pulses", 32'(pulse_cnt - base), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
